// File: rtl/operand_read_if.sv
`default_nettype none
// ============================================================================
//  Module   : operand_read_if
//  Purpose  : Bundles the issue, scoreboard-clear, register-array and
//             operand-output signals of operand_read.
//  Modports : slave  - operand_read side (consumes issue/arrays, drives operands)
//             master - surrounding pipeline side (issue stage, write units, EX)
//  Revision : 1.0 - initial release
// ============================================================================
interface operand_read_if #(
  parameter int NREG   = 32,
  parameter int W      = 32,
  parameter int SCNT_W = 16
);
  localparam int AW = $clog2(NREG);

  // issue side
  logic              issue_valid;
  logic              issue_ready;
  logic [AW-1:0]     rs_addr;
  logic [AW-1:0]     rt_addr;
  logic              rs_fp;
  logic              rt_fp;
  logic [AW-1:0]     rd_addr;
  logic              rd_fp;
  logic              rd_we;
  // register array contents
  logic [NREG*W-1:0] gpr;
  logic [NREG*W-1:0] fpr;
  // write completion notifications
  logic              wgpr_finish;
  logic [AW-1:0]     wgpr_addr;
  logic              wfpr_finish;
  logic [AW-1:0]     wfpr_addr;
  // execute side
  logic              op_valid;
  logic              op_ready;
  logic [W-1:0]      rs_data;
  logic [W-1:0]      rt_data;
  logic [SCNT_W-1:0] stall_cnt;

  modport slave (
    input  issue_valid, rs_addr, rt_addr, rs_fp, rt_fp, rd_addr, rd_fp, rd_we,
    input  gpr, fpr, wgpr_finish, wgpr_addr, wfpr_finish, wfpr_addr, op_ready,
    output issue_ready, op_valid, rs_data, rt_data, stall_cnt
  );

  modport master (
    output issue_valid, rs_addr, rt_addr, rs_fp, rt_fp, rd_addr, rd_fp, rd_we,
    output gpr, fpr, wgpr_finish, wgpr_addr, wfpr_finish, wfpr_addr, op_ready,
    input  issue_ready, op_valid, rs_data, rt_data, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/operand_read.sv
`default_nettype none
// ============================================================================
//  Module   : operand_read
//  Purpose  : Accepts one decoded instruction, waits until its source and
//             destination registers are free of outstanding writes (per-file
//             busy scoreboard), samples the GPR/FPR arrays and hands the
//             operand pair to execute over a valid/ready handshake.
//  Ports    : clk  - clock, rising edge
//             rstn - asynchronous active-low reset
//             bus  - operand_read_if.slave (issue, arrays, write finishes,
//                    operand outputs, saturating stall counter)
//  Revision : 1.0 - initial release
// ============================================================================
module operand_read #(
  parameter int NREG   = 32,
  parameter int W      = 32,
  parameter int SCNT_W = 16
) (
  input  logic           clk,
  input  logic           rstn,
  operand_read_if.slave  bus
);

  localparam int AW = $clog2(NREG);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t            state_q;

  // captured instruction
  logic [AW-1:0]     rs_addr_q, rt_addr_q, rd_addr_q;
  logic              rs_fp_q, rt_fp_q, rd_fp_q, rd_we_q;

  // scoreboard
  logic [NREG-1:0]   busy_g_q, busy_f_q;
  logic [NREG-1:0]   busy_g_d, busy_f_d;

  // registered outputs
  logic              issue_ready_q;
  logic              op_valid_q;
  logic [W-1:0]      rs_data_q, rt_data_q;
  logic [SCNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // unpacked views of the flat register arrays
  logic [W-1:0]      g_arr [NREG];
  logic [W-1:0]      f_arr [NREG];

  for (genvar i = 0; i < NREG; i++) begin : g_unpack
    assign g_arr[i] = bus.gpr[i*W +: W];
    assign f_arr[i] = bus.fpr[i*W +: W];
  end

  logic [NREG-1:0]   clr_g, clr_f, set_g, set_f;
  logic [NREG-1:0]   eff_g, eff_f;
  logic              rs_busy, rt_busy, rd_busy, hazard;
  logic [W-1:0]      rs_val, rt_val;

  always_comb begin
    clr_g = '0;
    clr_f = '0;
    if (bus.wgpr_finish) clr_g[bus.wgpr_addr] = 1'b1;
    if (bus.wfpr_finish) clr_f[bus.wfpr_addr] = 1'b1;

    // A write finishing this cycle already sits in the array, so its
    // hazard is released in the same cycle.
    eff_g    = busy_g_q & ~clr_g;
    eff_g[0] = 1'b0;
    eff_f    = busy_f_q & ~clr_f;

    rs_busy = rs_fp_q ? eff_f[rs_addr_q] : eff_g[rs_addr_q];
    rt_busy = rt_fp_q ? eff_f[rt_addr_q] : eff_g[rt_addr_q];
    rd_busy = rd_fp_q ? eff_f[rd_addr_q] : eff_g[rd_addr_q];
    hazard  = rs_busy | rt_busy | (rd_we_q & rd_busy);

    // Destination marked busy as the instruction leaves WAIT; gpr 0 is
    // hard-wired and never tracked.
    set_g = '0;
    set_f = '0;
    if (state_q == S_WAIT && !hazard && rd_we_q) begin
      if (rd_fp_q)                set_f[rd_addr_q] = 1'b1;
      else if (rd_addr_q != '0)   set_g[rd_addr_q] = 1'b1;
    end

    // Set wins over a same-cycle clear: the set is for the newer write.
    busy_g_d = (busy_g_q & ~clr_g) | set_g;
    busy_f_d = (busy_f_q & ~clr_f) | set_f;

    if (rs_fp_q)                rs_val = f_arr[rs_addr_q];
    else if (rs_addr_q == '0)   rs_val = '0;
    else                        rs_val = g_arr[rs_addr_q];

    if (rt_fp_q)                rt_val = f_arr[rt_addr_q];
    else if (rt_addr_q == '0)   rt_val = '0;
    else                        rt_val = g_arr[rt_addr_q];

    stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + SCNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      rs_addr_q     <= '0;
      rt_addr_q     <= '0;
      rd_addr_q     <= '0;
      rs_fp_q       <= 1'b0;
      rt_fp_q       <= 1'b0;
      rd_fp_q       <= 1'b0;
      rd_we_q       <= 1'b0;
      busy_g_q      <= '0;
      busy_f_q      <= '0;
      issue_ready_q <= 1'b1;
      op_valid_q    <= 1'b0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      stall_cnt_q   <= '0;
    end else begin
      // scoreboard clears apply in every state
      busy_g_q <= busy_g_d;
      busy_f_q <= busy_f_d;

      case (state_q)
        S_IDLE: begin
          if (bus.issue_valid) begin
            rs_addr_q     <= bus.rs_addr;
            rt_addr_q     <= bus.rt_addr;
            rd_addr_q     <= bus.rd_addr;
            rs_fp_q       <= bus.rs_fp;
            rt_fp_q       <= bus.rt_fp;
            rd_fp_q       <= bus.rd_fp;
            rd_we_q       <= bus.rd_we;
            issue_ready_q <= 1'b0;
            state_q       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (hazard) begin
            stall_cnt_q <= stall_cnt_d;
          end else begin
            rs_data_q  <= rs_val;
            rt_data_q  <= rt_val;
            op_valid_q <= 1'b1;
            state_q    <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.op_ready) begin
            op_valid_q    <= 1'b0;
            issue_ready_q <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        default: begin
          op_valid_q    <= 1'b0;
          issue_ready_q <= 1'b1;
          state_q       <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.issue_ready = issue_ready_q;
  assign bus.op_valid    = op_valid_q;
  assign bus.rs_data     = rs_data_q;
  assign bus.rt_data     = rt_data_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_read.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_read
//  Purpose  : Self-checking bench for operand_read: table of hazard-free
//             reads plus directed RAW/WAW/file-select/r0/hold/reset/saturation
//             sequences. A second instance with SCNT_W=4 shares stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operand_read;

  localparam int NREG = 32;
  localparam int W    = 32;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic              iv, rsf, rtf, rdf, we, wgf, wff, ordy;
  logic [4:0]        rs, rt, rd, wga, wfa;
  logic [NREG*W-1:0] gpr_v, fpr_v;

  operand_read_if #(.NREG(NREG), .W(W), .SCNT_W(16)) bus  ();
  operand_read_if #(.NREG(NREG), .W(W), .SCNT_W(4))  bus4 ();

  assign bus.issue_valid  = iv;    assign bus4.issue_valid  = iv;
  assign bus.rs_addr      = rs;    assign bus4.rs_addr      = rs;
  assign bus.rt_addr      = rt;    assign bus4.rt_addr      = rt;
  assign bus.rd_addr      = rd;    assign bus4.rd_addr      = rd;
  assign bus.rs_fp        = rsf;   assign bus4.rs_fp        = rsf;
  assign bus.rt_fp        = rtf;   assign bus4.rt_fp        = rtf;
  assign bus.rd_fp        = rdf;   assign bus4.rd_fp        = rdf;
  assign bus.rd_we        = we;    assign bus4.rd_we        = we;
  assign bus.gpr          = gpr_v; assign bus4.gpr          = gpr_v;
  assign bus.fpr          = fpr_v; assign bus4.fpr          = fpr_v;
  assign bus.wgpr_finish  = wgf;   assign bus4.wgpr_finish  = wgf;
  assign bus.wgpr_addr    = wga;   assign bus4.wgpr_addr    = wga;
  assign bus.wfpr_finish  = wff;   assign bus4.wfpr_finish  = wff;
  assign bus.wfpr_addr    = wfa;   assign bus4.wfpr_addr    = wfa;
  assign bus.op_ready     = ordy;  assign bus4.op_ready     = ordy;

  operand_read #(.NREG(NREG), .W(W), .SCNT_W(16)) dut  (.clk(clk), .rstn(rstn), .bus(bus));
  operand_read #(.NREG(NREG), .W(W), .SCNT_W(4))  dut4 (.clk(clk), .rstn(rstn), .bus(bus4));

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setg(input int i, input logic [31:0] v);
    gpr_v[i*W +: W] = v;
  endtask

  task automatic setf(input int i, input logic [31:0] v);
    fpr_v[i*W +: W] = v;
  endtask

  // presents one instruction for exactly one (accepting) clock edge
  task automatic issue(input logic [4:0] a_rs, input logic a_rsf,
                       input logic [4:0] a_rt, input logic a_rtf,
                       input logic [4:0] a_rd, input logic a_rdf, input logic a_we);
    rs = a_rs; rsf = a_rsf; rt = a_rt; rtf = a_rtf;
    rd = a_rd; rdf = a_rdf; we = a_we; iv = 1'b1;
    tick();
    iv = 1'b0;
  endtask

  // instruction that writes rd, run straight through to IDLE
  task automatic mark_busy(input logic [4:0] a_rd, input logic a_rdf);
    issue(5'd1, 1'b0, 5'd2, 1'b0, a_rd, a_rdf, 1'b1);
    tick();
    chk("mark_valid", {31'b0, bus.op_valid}, 32'd1);
    tick();
  endtask

  typedef struct {
    logic [4:0]  rs;
    logic        rsf;
    logic [4:0]  rt;
    logic        rtf;
    logic [31:0] ers;
    logic [31:0] ert;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{5'd3,  1'b0, 5'd4,  1'b0, 32'h11,  32'h22};
    tbl[1] = '{5'd0,  1'b0, 5'd5,  1'b0, 32'h0,   32'h105};
    tbl[2] = '{5'd0,  1'b1, 5'd9,  1'b1, 32'h200, 32'h209};
    tbl[3] = '{5'd7,  1'b1, 5'd7,  1'b0, 32'h207, 32'h107};
    tbl[4] = '{5'd31, 1'b0, 5'd31, 1'b0, 32'h11F, 32'h11F};
    tbl[5] = '{5'd31, 1'b1, 5'd0,  1'b0, 32'h21F, 32'h0};

    for (int i = 0; i < NREG; i++) begin
      setg(i, 32'h100 + i);
      setf(i, 32'h200 + i);
    end
    setg(0, 32'hFFFF);
    setg(3, 32'h11);
    setg(4, 32'h22);

    iv = 0; rs = 0; rt = 0; rd = 0; rsf = 0; rtf = 0; rdf = 0; we = 0;
    wgf = 0; wga = 0; wff = 0; wfa = 0; ordy = 1;
    rstn = 1'b0;
    tick();
    tick();
    chk("rst_issue_ready", {31'b0, bus.issue_ready}, 32'd1);
    chk("rst_op_valid",    {31'b0, bus.op_valid},    32'd0);
    chk("rst_rs_data",     bus.rs_data,              32'd0);
    chk("rst_rt_data",     bus.rt_data,              32'd0);
    chk("rst_stall",       {16'b0, bus.stall_cnt},   32'd0);
    rstn = 1'b1;
    tick();

    // ---------------- hazard-free table ----------------
    for (int v = 0; v < 6; v++) begin
      issue(tbl[v].rs, tbl[v].rsf, tbl[v].rt, tbl[v].rtf, 5'd0, 1'b0, 1'b0);
      chk("tbl_valid_early", {31'b0, bus.op_valid},    32'd0);
      chk("tbl_ready_busy",  {31'b0, bus.issue_ready}, 32'd0);
      tick();
      chk("tbl_valid", {31'b0, bus.op_valid}, 32'd1);
      chk("tbl_rs",    bus.rs_data, tbl[v].ers);
      chk("tbl_rt",    bus.rt_data, tbl[v].ert);
      tick();
      chk("tbl_valid_drop", {31'b0, bus.op_valid},    32'd0);
      chk("tbl_ready_back", {31'b0, bus.issue_ready}, 32'd1);
    end
    chk("tbl_stall", {16'b0, bus.stall_cnt}, 32'd0);

    // ---------------- GPR RAW stall, same-cycle release ----------------
    mark_busy(5'd5, 1'b0);
    issue(5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_stall++;
      chk("raw_stalled", {31'b0, bus.op_valid}, 32'd0);
    end
    setg(5, 32'hABCD);
    wgf = 1'b1; wga = 5'd5;
    tick();
    wgf = 1'b0;
    chk("raw_valid", {31'b0, bus.op_valid}, 32'd1);
    chk("raw_rs",    bus.rs_data, 32'hABCD);
    chk("raw_rt",    bus.rt_data, 32'h0);
    chk("raw_stall", {16'b0, bus.stall_cnt}, exp_stall);
    tick();
    issue(5'd5, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("raw_cleared", {31'b0, bus.op_valid}, 32'd1);
    chk("same_rs",     bus.rs_data, 32'hABCD);
    chk("same_rt",     bus.rt_data, 32'hABCD);
    tick();

    // ---------------- GPR 0 ----------------
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    chk("r0_valid", {31'b0, bus.op_valid}, 32'd1);
    chk("r0_rs",    bus.rs_data, 32'h0);
    tick();
    issue(5'd0, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("r0_no_stall", {31'b0, bus.op_valid}, 32'd1);
    chk("r0_rt",       bus.rt_data, 32'h11);
    chk("r0_stall",    {16'b0, bus.stall_cnt}, exp_stall);
    tick();

    // ---------------- FPR path / file separation ----------------
    mark_busy(5'd7, 1'b1);
    issue(5'd7, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    tick();
    chk("fp_other_file", {31'b0, bus.op_valid}, 32'd1);
    chk("fp_gpr7",       bus.rs_data, 32'h107);
    chk("fp_fpr0",       bus.rt_data, 32'h200);
    tick();
    issue(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      exp_stall++;
      chk("fp_stalled", {31'b0, bus.op_valid}, 32'd0);
    end
    wgf = 1'b1; wga = 5'd7;
    tick();
    wgf = 1'b0;
    exp_stall++;
    chk("fp_wrong_clear", {31'b0, bus.op_valid}, 32'd0);
    setf(7, 32'h5A5A);
    wff = 1'b1; wfa = 5'd7;
    tick();
    wff = 1'b0;
    chk("fp_valid", {31'b0, bus.op_valid}, 32'd1);
    chk("fp_rs",    bus.rs_data, 32'h5A5A);
    chk("fp_stall", {16'b0, bus.stall_cnt}, exp_stall);
    tick();

    // ---------------- WAW, set wins over same-cycle clear ----------------
    mark_busy(5'd9, 1'b0);
    issue(5'd1, 1'b0, 5'd2, 1'b0, 5'd9, 1'b0, 1'b1);
    tick();
    exp_stall++;
    chk("waw_stalled", {31'b0, bus.op_valid}, 32'd0);
    wgf = 1'b1; wga = 5'd9;
    tick();
    wgf = 1'b0;
    chk("waw_valid", {31'b0, bus.op_valid}, 32'd1);
    tick();
    issue(5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    exp_stall++;
    chk("set_wins", {31'b0, bus.op_valid}, 32'd0);
    wgf = 1'b1; wga = 5'd9;
    tick();
    wgf = 1'b0;
    chk("set_wins_rel", {31'b0, bus.op_valid}, 32'd1);
    chk("set_wins_rs",  bus.rs_data, 32'h109);
    chk("waw_stall",    {16'b0, bus.stall_cnt}, exp_stall);
    tick();

    // ---------------- hold in OUT, then async reset ----------------
    mark_busy(5'd12, 1'b0);
    ordy = 1'b0;
    issue(5'd3, 1'b0, 5'd4, 1'b0, 5'd13, 1'b0, 1'b1);
    tick();
    chk("hold_valid", {31'b0, bus.op_valid}, 32'd1);
    setg(3, 32'hDEAD);
    setg(4, 32'hBEEF);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_valid_k", {31'b0, bus.op_valid},    32'd1);
      chk("hold_rs",      bus.rs_data,              32'h11);
      chk("hold_rt",      bus.rt_data,              32'h22);
      chk("hold_ready",   {31'b0, bus.issue_ready}, 32'd0);
    end
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid", {31'b0, bus.op_valid},    32'd0);
    chk("arst_ready", {31'b0, bus.issue_ready}, 32'd1);
    chk("arst_rs",    bus.rs_data,              32'h0);
    chk("arst_stall", {16'b0, bus.stall_cnt},   32'd0);
    @(negedge clk);
    rstn = 1'b1;
    ordy = 1'b1;
    exp_stall = 0;
    tick();
    issue(5'd12, 1'b0, 5'd13, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("arst_busy_clr", {31'b0, bus.op_valid}, 32'd1);
    chk("arst_rs12",     bus.rs_data, 32'h10C);
    chk("arst_rt13",     bus.rt_data, 32'h10D);
    tick();

    // ---------------- stall counter saturation ----------------
    mark_busy(5'd20, 1'b0);
    issue(5'd20, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_stall++;
    end
    chk("sat_stalled", {31'b0, bus.op_valid},   32'd0);
    chk("sat_cnt16",   {16'b0, bus.stall_cnt},  exp_stall);
    chk("sat_cnt4",    {28'b0, bus4.stall_cnt}, 32'd15);
    wgf = 1'b1; wga = 5'd20;
    tick();
    wgf = 1'b0;
    chk("sat_valid",   {31'b0, bus.op_valid},   32'd1);
    chk("sat_valid4",  {31'b0, bus4.op_valid},  32'd1);
    chk("sat_rs",      bus.rs_data,             32'h114);
    chk("sat_cnt4_hold", {28'b0, bus4.stall_cnt}, 32'd15);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
